// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID-stage forwarding/hazard logic.
// Scoreboard entries carry a fixed-width register tag so the struct can live
// in a package; instances zero-extend their AW-bit addresses into it, so AW
// must not exceed RD_W.
package pipe_pkg;

  localparam int unsigned RD_W = 8;

  // Forward-select encoding: 0 reads the register file, i takes the pipeline
  // register that follows scoreboard entry i.
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam logic [RD_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            wr;
    logic            ld;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/fwd_src_resolve.sv
// Resolves one ID source operand against the in-flight scoreboard: finds the
// youngest producer of the operand and decides between forwarding and stalling.
module fwd_src_resolve
  import pipe_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SW       = $clog2(DEPTH)
) (
  input  sb_entry_t        sb_i [DEPTH],
  input  logic [AW-1:0]    src_addr_i,
  input  logic             src_used_i,
  input  logic             id_valid_i,
  input  logic             id_is_branch_i,
  output logic [SW-1:0]    sel_o,
  output logic             stall_o
);

  logic [DEPTH-1:0] match;
  logic             found;
  logic [SW-1:0]    hit_idx;
  logic             hit_ld;
  logic [SW:0]      ready_idx;
  logic [SW:0]      hit_ext;

  // Per-entry match: a live register-writing producer of this operand's source.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = sb_i[i].valid && sb_i[i].wr && (sb_i[i].rd != REG_ZERO) &&
                 (sb_i[i].rd == RD_W'(src_addr_i)) && src_used_i && id_valid_i;
    end
  end

  // Scan oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    hit_ld  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        found   = 1'b1;
        hit_idx = SW'(i);
        hit_ld  = sb_i[i].ld;
      end
    end
  end

  // A branch compares in ID now; other instructions consume the operand in EX
  // one cycle later, so they tolerate a producer one entry younger.
  always_comb begin
    sel_o     = SW'(FWD_RF);
    stall_o   = 1'b0;
    ready_idx = hit_ld ? (SW+1)'(LOAD_LAT) : (SW+1)'(1);
    hit_ext   = {1'b0, hit_idx};
    if (found) begin
      if (id_is_branch_i) begin
        if (hit_ext >= ready_idx) begin
          sel_o = hit_idx;
        end else begin
          stall_o = 1'b1;
        end
      end else if ((hit_ext + (SW+1)'(1)) < ready_idx) begin
        stall_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_fwd_hazard_unit.sv
// ID-stage forwarding and hazard unit. Tracks in-flight destinations in a
// private shift-register scoreboard and produces per-operand forward selects,
// a pipeline stall request and a saturating stall-cycle counter.
module cmp_fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SW       = $clog2(DEPTH),
  parameter int CW       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_is_branch,
  input  logic [NUM_SRC*AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic                  id_reg_write,
  input  logic [AW-1:0]         id_dst_addr,
  input  logic                  id_is_load,
  input  logic                  pipe_freeze,
  input  logic                  id_flush,
  output logic [NUM_SRC*SW-1:0] fwd_sel,
  output logic                  hazard_stall,
  output logic [CW-1:0]         stall_cycles
);

  sb_entry_t            sb_q [DEPTH];
  sb_entry_t            sb_d [DEPTH];
  sb_entry_t            id_entry;
  logic [NUM_SRC-1:0]   src_stall;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_resolve #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SW       (SW)
    ) u_resolve (
      .sb_i           (sb_q),
      .src_addr_i     (id_src_addr[k*AW +: AW]),
      .src_used_i     (id_src_used[k]),
      .id_valid_i     (id_valid),
      .id_is_branch_i (id_is_branch),
      .sel_o          (fwd_sel[k*SW +: SW]),
      .stall_o        (src_stall[k])
    );
  end

  assign hazard_stall = id_valid && (|src_stall);
  assign stall_cycles = cnt_q;

  // Next scoreboard: age every entry by one and admit the ID instruction only
  // when it actually leaves ID; stalled or flushed slots become bubbles.
  always_comb begin
    id_entry       = SB_BUBBLE;
    id_entry.valid = 1'b1;
    id_entry.rd    = RD_W'(id_dst_addr);
    id_entry.wr    = id_reg_write;
    id_entry.ld    = id_is_load;
    for (int i = 1; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
    sb_d[0] = (id_valid && !hazard_stall && !id_flush) ? id_entry : SB_BUBBLE;
  end

  // Stall counter saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State advances only when the pipeline moves; a freeze holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= SB_BUBBLE;
      end
      cnt_q <= '0;
    end else if (!pipe_freeze) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
